// File: rtl/tone_pkg.sv
// ============================================================================
// Module  : tone_pkg
// Purpose : Shared definitions for the tone sequencer: command encodings,
//           notes-per-octave constant and the base-octave frequency table.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tone_pkg;

  localparam int NOTES_PER_OCT = 7;
  localparam int OCT_W         = 3;   // up to 56 notes -> octave 0..7

  typedef enum logic [2:0] {
    CMD_UP      = 3'd0,
    CMD_DOWN    = 3'd1,
    CMD_FASTER  = 3'd2,
    CMD_SLOWER  = 3'd3,
    CMD_PAUSE   = 3'd4,
    CMD_RESTART = 3'd5
  } cmd_e;

  // Lowest-octave frequencies in Hz (C4..B4). Higher octaves are derived by
  // shifting left, so no divider or large table is needed.
  function automatic logic [15:0] base_freq(input logic [2:0] note);
    logic [15:0] f;
    case (note)
      3'd0:    f = 16'd262;
      3'd1:    f = 16'd294;
      3'd2:    f = 16'd330;
      3'd3:    f = 16'd349;
      3'd4:    f = 16'd392;
      3'd5:    f = 16'd440;
      3'd6:    f = 16'd494;
      default: f = 16'd0;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_timer.sv
// ============================================================================
// Module  : step_timer
// Purpose : Free-running period counter for the tone sequencer. Counts
//           0..period-1 where period = CLK_HZ >> level, then wraps.
// Ports   : clk      in  system clock
//           rst      in  synchronous active-high reset
//           level    in  speed level selecting the period
//           clear    in  force the count back to 0 (wins over freeze)
//           freeze   in  hold the count
//           terminal out count is at period-1
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module step_timer #(
  parameter int CLK_HZ = 100_000_000,
  parameter int LVL_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] level,
  input  logic             clear,
  input  logic             freeze,
  output logic             terminal
);

  localparam int CNT_W = $clog2(CLK_HZ + 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period;

  assign period   = CNT_W'(CLK_HZ >> level);
  assign terminal = (count == period - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (!freeze) begin
      count <= terminal ? '0 : count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tone_sequencer.sv
// ============================================================================
// Module  : tone_sequencer
// Purpose : Steps a note index up/down a scale at a selectable rate and
//           presents the tone frequency (Hz) to the PWM generator.
// Ports   : clk, rst (sync, active-high)
//           cmd_valid/cmd  one-cycle command strobe (UP, DOWN, FASTER,
//                          SLOWER, PAUSE toggle, RESTART; 6-7 ignored)
//           freq, note_idx registered tone and index
//           dir, speed, paused   current stepping state
//           step_pulse     high in the cycle whose closing edge steps
//           at_top, at_bottom    index boundary flags
// Config  : TONE_SEQ_PINGPONG_EN - bounce off the scale ends instead of
//           holding there.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_sequencer
  import tone_pkg::*;
#(
  parameter int NUM_NOTES  = 29,
  parameter int CLK_HZ     = 100_000_000,
  parameter int NUM_SPEEDS = 4,
  parameter int FREQ_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  input  logic [2:0]                    cmd,
  output logic [FREQ_W-1:0]             freq,
  output logic [$clog2(NUM_NOTES)-1:0]  note_idx,
  output logic                          dir,
  output logic [$clog2(NUM_SPEEDS)-1:0] speed,
  output logic                          paused,
  output logic                          step_pulse,
  output logic                          at_top,
  output logic                          at_bottom
);

  localparam int IDX_W = $clog2(NUM_NOTES);
  localparam int SPD_W = $clog2(NUM_SPEEDS);

  logic [2:0]        note, note_n;
  logic [OCT_W-1:0]  octave, octave_n;
  logic [IDX_W-1:0]  idx_n;
  logic              dir_n, paused_n;
  logic [SPD_W-1:0]  speed_n;
  logic [FREQ_W-1:0] freq_n;
  logic              go_up, go_down, timer_clear, terminal;

  step_timer #(
    .CLK_HZ (CLK_HZ),
    .LVL_W  (SPD_W)
  ) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .level    (speed),
    .clear    (timer_clear),
    .freeze   (paused),
    .terminal (terminal)
  );

  assign step_pulse = terminal && !paused;
  assign at_top     = (note_idx == IDX_W'(NUM_NOTES - 1));
  assign at_bottom  = (note_idx == '0);

  always_comb begin
    note_n      = note;
    octave_n    = octave;
    idx_n       = note_idx;
    dir_n       = dir;
    speed_n     = speed;
    paused_n    = paused;
    timer_clear = 1'b0;
    go_up       = 1'b0;
    go_down     = 1'b0;

    // Direction commands are applied first so a boundary reversal below can
    // override them; a regular step still uses the registered dir.
    if (cmd_valid && cmd == CMD_UP)   dir_n = 1'b0;
    if (cmd_valid && cmd == CMD_DOWN) dir_n = 1'b1;

    if (step_pulse) begin
      if (!dir) begin
        if (!at_top) begin
          go_up = 1'b1;
        end else begin
`ifdef TONE_SEQ_PINGPONG_EN
          dir_n   = 1'b1;
          go_down = 1'b1;
`endif
        end
      end else begin
        if (!at_bottom) begin
          go_down = 1'b1;
        end else begin
`ifdef TONE_SEQ_PINGPONG_EN
          dir_n = 1'b0;
          go_up = 1'b1;
`endif
        end
      end
    end

    if (go_up) begin
      idx_n = note_idx + IDX_W'(1);
      if (note == 3'(NOTES_PER_OCT - 1)) begin
        note_n   = 3'd0;
        octave_n = octave + OCT_W'(1);
      end else begin
        note_n = note + 3'd1;
      end
    end else if (go_down) begin
      idx_n = note_idx - IDX_W'(1);
      if (note == 3'd0) begin
        note_n   = 3'(NOTES_PER_OCT - 1);
        octave_n = octave - OCT_W'(1);
      end else begin
        note_n = note - 3'd1;
      end
    end

    if (cmd_valid && cmd == CMD_FASTER && speed != SPD_W'(NUM_SPEEDS - 1)) begin
      speed_n     = speed + SPD_W'(1);
      timer_clear = 1'b1;
    end
    if (cmd_valid && cmd == CMD_SLOWER && speed != '0) begin
      speed_n     = speed - SPD_W'(1);
      timer_clear = 1'b1;
    end
    if (cmd_valid && cmd == CMD_PAUSE) paused_n = !paused;

    // Restart wins over any step or direction change in the same cycle.
    if (cmd_valid && cmd == CMD_RESTART) begin
      note_n      = 3'd0;
      octave_n    = '0;
      idx_n       = '0;
      dir_n       = 1'b0;
      paused_n    = 1'b0;
      timer_clear = 1'b1;
    end

    freq_n = FREQ_W'(base_freq(note_n)) << octave_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note     <= 3'd0;
      octave   <= '0;
      note_idx <= '0;
      dir      <= 1'b0;
      speed    <= '0;
      paused   <= 1'b0;
      freq     <= FREQ_W'(262);
    end else begin
      note     <= note_n;
      octave   <= octave_n;
      note_idx <= idx_n;
      dir      <= dir_n;
      speed    <= speed_n;
      paused   <= paused_n;
      freq     <= freq_n;
    end
  end

endmodule

`default_nettype wire
